multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle RV32I controller and its datapath.
// master: the controller (consumes IR/compare/memory status, drives selects).
// slave:  the datapath and memory side.
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic        br_taken;
  logic        mem_ready;
  logic [2:0]  state;
  logic [2:0]  imm_sel;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_data;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        illegal_inst;

  modport master (
    input  inst, br_taken, mem_ready,
    output state, imm_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, mem_req, mem_we, mem_is_data, reg_write, wb_sel, illegal_inst
  );

  modport slave (
    output inst, br_taken, mem_ready,
    input  state, imm_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, mem_req, mem_we, mem_is_data, reg_write, wb_sel, illegal_inst
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I datapath: fetch, decode, execute,
// memory and writeback over one shared single-port memory.
// Optional feature macro: MCTRL_ILLEGAL_TRAP_EN (unrecognised opcode traps
// instead of being retired as a NOP).
// Immediate format codes normally come from defines.v; fall back to the
// shared encoding when that file is not part of the build.
//
// state  | meaning
// IDLE   | just out of reset, no activity
// FETCH  | instruction read from memory, IR loads on mem_ready
// DECODE | opcode classification, one cycle
// EXEC   | ALU operation; branches and jumps retire here
// MEM    | data read/write, waits for mem_ready
// WB     | register write and PC+4
// TRAP   | illegal opcode seen, parked until reset
`ifndef I_TYPE_IMM
`define I_TYPE_IMM 3'd0
`endif
`ifndef S_TYPE_IMM
`define S_TYPE_IMM 3'd1
`endif
`ifndef B_TYPE_IMM
`define B_TYPE_IMM 3'd2
`endif
`ifndef U_TYPE_IMM
`define U_TYPE_IMM 3'd3
`endif
`ifndef J_TYPE_IMM
`define J_TYPE_IMM 3'd4
`endif

module multicycle_ctrl (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, recognised;
  logic       unused_inst_hi;

  logic [2:0] imm_sel;
  logic       ir_write, pc_write, alu_src_b, mem_req, mem_we, mem_is_data;
  logic       reg_write, illegal_inst;
  logic [1:0] pc_src, alu_src_a, alu_op, wb_sel;

  assign opcode         = bus.inst[6:0];
  assign unused_inst_hi = ^bus.inst[31:7];

  assign is_lui     = (opcode == OPC_LUI);
  assign is_auipc   = (opcode == OPC_AUIPC);
  assign is_jal     = (opcode == OPC_JAL);
  assign is_jalr    = (opcode == OPC_JALR);
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_opimm   = (opcode == OPC_OPIMM);
  assign is_op      = (opcode == OPC_OP);
  assign recognised = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                      is_load | is_store | is_opimm | is_op;

  // Immediate format straight from the IR opcode, independent of state.
  always_comb begin
    imm_sel = `I_TYPE_IMM;
    if (is_store)                 imm_sel = `S_TYPE_IMM;
    else if (is_branch)           imm_sel = `B_TYPE_IMM;
    else if (is_lui || is_auipc)  imm_sel = `U_TYPE_IMM;
    else if (is_jal)              imm_sel = `J_TYPE_IMM;
  end

  // State register; reset abandons any in-flight memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state datapath strobes.
  always_comb begin
    state_d      = state_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 2'd0;
    alu_src_b    = 1'b0;
    alu_op       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_data  = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    illegal_inst = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (recognised) begin
          state_d = EXEC;
        end else begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          // Unknown opcode retires as a NOP.
          pc_write = 1'b1;
          state_d  = FETCH;
`endif
        end
      end
      EXEC: begin
        state_d = FETCH;
        if (is_op) begin
          alu_op  = 2'd2;
          state_d = WB;
        end else if (is_opimm) begin
          alu_src_b = 1'b1;
          alu_op    = 2'd2;
          state_d   = WB;
        end else if (is_lui) begin
          alu_src_a = 2'd2;
          alu_src_b = 1'b1;
          state_d   = WB;
        end else if (is_auipc) begin
          alu_src_a = 2'd1;
          alu_src_b = 1'b1;
          state_d   = WB;
        end else if (is_load || is_store) begin
          alu_src_b = 1'b1;
          state_d   = MEM;
        end else if (is_branch) begin
          alu_op   = 2'd1;
          pc_write = 1'b1;
          pc_src   = bus.br_taken ? 2'd1 : 2'd0;
        end else if (is_jal || is_jalr) begin
          // Link and PC commit together, so the link sees the old PC.
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          pc_write  = 1'b1;
          pc_src    = is_jal ? 2'd1 : 2'd2;
        end
      end
      MEM: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load ? 2'd1 : 2'd0;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      TRAP: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal_inst = 1'b1;
        state_d      = TRAP;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.imm_sel      = imm_sel;
  assign bus.ir_write     = ir_write;
  assign bus.pc_write     = pc_write;
  assign bus.pc_src       = pc_src;
  assign bus.alu_src_a    = alu_src_a;
  assign bus.alu_src_b    = alu_src_b;
  assign bus.alu_op       = alu_op;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_is_data  = mem_is_data;
  assign bus.reg_write    = reg_write;
  assign bus.wb_sel       = wb_sel;
  assign bus.illegal_inst = illegal_inst;

endmodule
